// File: rtl/i_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i_cache_pkg
//  Brief    : Shared widths, zero word and FSM state encoding for i_cache.
//  Revision : 1.0  initial release
// ============================================================================
package i_cache_pkg;

    localparam int ICACHE_ADDR_LEN   = 32;
    localparam int ICACHE_INST_LEN   = 32;
    localparam int ICACHE_INDEX_BITS = 7;

    localparam logic [ICACHE_INST_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ICACHE_IDLE = 2'd0,
        ICACHE_REQ  = 2'd1,
        ICACHE_WAIT = 2'd2,
        ICACHE_FILL = 2'd3
    } icache_state_e;

endpackage
`default_nettype wire

// File: rtl/i_cache_if.sv
`default_nettype none
// ============================================================================
//  Module   : i_cache_if
//  Brief    : Fetch-side and memory-controller-side signals of the i_cache.
//             slave = cache side, master = fetch stage / memory controller.
//  Revision : 1.0  initial release
// ============================================================================
interface i_cache_if
    import i_cache_pkg::*;
#(
    parameter int ADDR_LEN = ICACHE_ADDR_LEN,
    parameter int INST_LEN = ICACHE_INST_LEN
);
    logic [ADDR_LEN-1:0] addr;
    logic                inst_available;
    logic [INST_LEN-1:0] inst;
    logic                mem_rd;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_gnt;
    logic [7:0]          mem_din;

    modport slave (
        input  addr, mem_gnt, mem_din,
        output inst_available, inst, mem_rd, mem_addr
    );

    modport master (
        output addr, mem_gnt, mem_din,
        input  inst_available, inst, mem_rd, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/i_cache_array.sv
`default_nettype none
// ============================================================================
//  Module   : i_cache_array
//  Brief    : Direct-mapped data/tag/valid storage. Combinational read port,
//             synchronous write port, valid bits cleared on reset.
//  Revision : 1.0  initial release
// ============================================================================
module i_cache_array
    import i_cache_pkg::*;
#(
    parameter int  INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int  ADDR_LEN   = ICACHE_ADDR_LEN,
    parameter int  INST_LEN   = ICACHE_INST_LEN,
    localparam int TAG_BITS   = ADDR_LEN - INDEX_BITS - 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [INDEX_BITS-1:0] rd_index_i,
    output logic                       rd_valid_o,
    output logic [TAG_BITS-1:0]        rd_tag_o,
    output logic [INST_LEN-1:0]        rd_data_o,
    input  wire logic                  we_i,
    input  wire logic [INDEX_BITS-1:0] wr_index_i,
    input  wire logic [TAG_BITS-1:0]   wr_tag_i,
    input  wire logic [INST_LEN-1:0]   wr_data_i
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [INST_LEN-1:0] data_q [LINES];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

    // Valid bits: cleared on reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data payload need no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i_cache.sv
`default_nettype none
// ============================================================================
//  Module   : i_cache
//  Brief    : Direct-mapped read-only instruction cache. Zero-latency hit
//             path; misses fetch the word byte-by-byte (little-endian) from
//             the memory controller, then fill the line.
//  Revision : 1.0  initial release
// ============================================================================
module i_cache
    import i_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_LEN   = ICACHE_ADDR_LEN,
    parameter int INST_LEN   = ICACHE_INST_LEN
) (
    input  wire logic clk,
    input  wire logic rst,
    i_cache_if.slave  bus
);
    localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

    icache_state_e       state_q, state_d;
    logic [ADDR_LEN-1:0] miss_addr_q, miss_addr_d;
    logic [1:0]          req_cnt_q, req_cnt_d;
    logic [1:0]          rcv_cnt_q, rcv_cnt_d;
    logic                acc_q, acc_d;
    logic [3:0][7:0]     buf_q, buf_d;

    logic                  w_rd_valid;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [INST_LEN-1:0]   w_rd_data;
    logic                  w_hit;
    logic                  w_we;
    logic                  w_mem_rd;
    logic [ADDR_LEN-1:0]   w_mem_addr;
    logic                  w_unused_offset;

    // The byte offset of the fetch address plays no part in lookup.
    assign w_unused_offset = ^bus.addr[1:0];

    i_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .ADDR_LEN   (ADDR_LEN),
        .INST_LEN   (INST_LEN)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (bus.addr[INDEX_BITS+1:2]),
        .rd_valid_o (w_rd_valid),
        .rd_tag_o   (w_rd_tag),
        .rd_data_o  (w_rd_data),
        .we_i       (w_we),
        .wr_index_i (miss_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (miss_addr_q[ADDR_LEN-1:INDEX_BITS+2]),
        .wr_data_i  (buf_q)
    );

    // Hit path is independent of the FSM; during FILL it sees the old array.
    assign w_hit              = w_rd_valid && (w_rd_tag == bus.addr[ADDR_LEN-1:INDEX_BITS+2]);
    assign bus.inst_available = w_hit;
    assign bus.inst           = w_hit ? w_rd_data : ZERO_WORD;
    assign bus.mem_rd         = w_mem_rd;
    assign bus.mem_addr       = w_mem_addr;

    // Next-state, request generation and byte capture.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        req_cnt_d   = req_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        buf_d       = buf_q;
        w_mem_rd    = 1'b0;
        w_mem_addr  = '0;
        w_we        = 1'b0;

        // A byte arrives the cycle after each accepted request.
        if (acc_q) begin
            buf_d[rcv_cnt_q] = bus.mem_din;
            rcv_cnt_d        = rcv_cnt_q + 2'd1;
        end

        case (state_q)
            ICACHE_IDLE: begin
                if (!w_hit) begin
                    miss_addr_d = {bus.addr[ADDR_LEN-1:2], 2'b00};
                    req_cnt_d   = 2'd0;
                    rcv_cnt_d   = 2'd0;
                    state_d     = ICACHE_REQ;
                end
            end
            ICACHE_REQ: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = miss_addr_q + {{(ADDR_LEN-2){1'b0}}, req_cnt_q};
                if (bus.mem_gnt) begin
                    req_cnt_d = req_cnt_q + 2'd1;
                    if (req_cnt_q == 2'd3) begin
                        state_d = ICACHE_WAIT;
                    end
                end
            end
            ICACHE_WAIT: begin
                state_d = ICACHE_FILL;
            end
            ICACHE_FILL: begin
                w_we    = 1'b1;
                state_d = ICACHE_IDLE;
            end
            default: begin
                state_d = ICACHE_IDLE;
            end
        endcase

        acc_d = w_mem_rd && bus.mem_gnt;
    end

    // State and datapath registers; reset abandons any fill in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ICACHE_IDLE;
            miss_addr_q <= '0;
            req_cnt_q   <= 2'd0;
            rcv_cnt_q   <= 2'd0;
            acc_q       <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            req_cnt_q   <= req_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            acc_q       <= acc_d;
            buf_q       <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i_cache
//  Brief    : Self-checking bench for i_cache: directed scenarios followed by
//             randomized fetch/grant/reset traffic against a cache model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i_cache;

    logic clk;
    logic rst;
    i_cache_if bus ();

    i_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: whole-word cache contents plus miss progress.
    bit          m_valid [128];
    logic [22:0] m_tag   [128];
    logic [31:0] m_data  [128];
    bit          m_known = 0;
    bit          m_busy  = 0;
    logic [31:0] m_miss  = '0;
    int          m_grants = 0;
    int          m_post   = 0;

    // Responder state and last observed outputs.
    bit          p_acc  = 0;
    logic [31:0] p_addr = '0;
    logic        o_av, o_rd;
    logic [31:0] o_inst, o_maddr;

    function automatic logic [31:0] memw(input logic [31:0] wa);
        if (wa == 32'h0000_1004) return 32'h0010_0513;
        return (wa * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = memw({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic tick(input logic [31:0] a, input logic g, input logic r);
        int          idx;
        bit          e_hit, e_rd;
        logic [31:0] e_inst, e_maddr;
        bus.mem_din = p_acc ? mem_byte(p_addr) : 8'h00;
        bus.addr    = a;
        bus.mem_gnt = g;
        rst         = r;
        #4;
        idx     = int'(a[8:2]);
        e_hit   = m_valid[idx] && (m_tag[idx] == a[31:9]);
        e_inst  = e_hit ? m_data[idx] : 32'h0;
        e_rd    = m_busy && (m_grants < 4);
        e_maddr = m_miss + 32'(m_grants);
        o_av    = bus.inst_available;
        o_inst  = bus.inst;
        o_rd    = bus.mem_rd;
        o_maddr = bus.mem_addr;
        if (m_known) begin
            chk1 ("model_inst_available", o_av, e_hit);
            chk32("model_inst", o_inst, e_inst);
            chk1 ("model_mem_rd", o_rd, e_rd);
            if (e_rd) chk32("model_mem_addr", o_maddr, e_maddr);
        end
        p_acc  = (o_rd === 1'b1) && g;
        p_addr = o_maddr;
        if (!r) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_busy  = 0;
            m_known = 1;
        end else if (m_known) begin
            if (!m_busy) begin
                if (!e_hit) begin
                    m_busy   = 1;
                    m_miss   = {a[31:2], 2'b00};
                    m_grants = 0;
                end
            end else if (m_grants < 4) begin
                if (g) begin
                    m_grants++;
                    if (m_grants == 4) m_post = 2;
                end
            end else begin
                m_post--;
                if (m_post == 0) begin
                    m_valid[m_miss[8:2]] = 1;
                    m_tag[m_miss[8:2]]   = m_miss[31:9];
                    m_data[m_miss[8:2]]  = memw(m_miss);
                    m_busy = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_hit(input logic [31:0] a, input int limit);
        bit found = 0;
        int n = 0;
        while (!found && n < limit) begin
            tick(a, 1'b1, 1'b1);
            found = (o_av === 1'b1);
            n++;
        end
        chk1("hit_within_bound", found, 1'b1);
    endtask

    initial begin
        bus.addr = '0; bus.mem_gnt = 1'b0; bus.mem_din = '0; rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles.
        for (int c = 0; c < 3; c++) begin
            tick(32'h0, 1'b1, 1'b0);
            if (c > 0) begin
                chk1 ("rst_inst_available", o_av, 1'b0);
                chk32("rst_inst", o_inst, 32'h0);
                chk1 ("rst_mem_rd", o_rd, 1'b0);
            end
        end
        tick(32'h0, 1'b1, 1'b1);
        chk1("post_rst_c0_mem_rd", o_rd, 1'b0);
        tick(32'h0, 1'b1, 1'b1);
        chk1 ("post_rst_c1_mem_rd", o_rd, 1'b1);
        chk32("post_rst_c1_mem_addr", o_maddr, 32'h0);
        run_until_hit(32'h0, 20);

        // Cold miss, continuous grant.
        for (int c = 0; c < 10; c++) begin
            tick(32'h0000_1004, 1'b1, 1'b1);
            if (c >= 1 && c <= 4) begin
                chk1 ("cold_mem_rd", o_rd, 1'b1);
                chk32("cold_mem_addr", o_maddr, 32'h0000_1004 + 32'(c - 1));
            end
            if (c < 7) chk1("cold_no_hit", o_av, 1'b0);
            else begin
                chk1 ("cold_hit", o_av, 1'b1);
                chk32("cold_inst", o_inst, 32'h0010_0513);
            end
        end

        // Same miss with grant stalls on cycles 2 and 3.
        tick(32'h0000_1004, 1'b1, 1'b0);
        tick(32'h0000_1004, 1'b1, 1'b0);
        for (int c = 0; c < 11; c++) begin
            tick(32'h0000_1004, !(c == 2 || c == 3), 1'b1);
            if (c >= 2 && c <= 4) chk32("stall_mem_addr", o_maddr, 32'h0000_1005);
            if (c < 9) chk1("stall_no_hit", o_av, 1'b0);
            else begin
                chk1 ("stall_hit", o_av, 1'b1);
                chk32("stall_inst", o_inst, 32'h0010_0513);
            end
        end

        // Conflict eviction at index 0.
        run_until_hit(32'h0, 30);
        run_until_hit(32'h0000_0200, 30);
        tick(32'h0, 1'b1, 1'b1);
        chk1("evict_miss", o_av, 1'b0);
        tick(32'h0, 1'b1, 1'b1);
        chk1 ("evict_refetch_rd", o_rd, 1'b1);
        chk32("evict_refetch_addr", o_maddr, 32'h0);
        run_until_hit(32'h0, 30);

        // Redirect to a cached address mid-miss.
        for (int c = 0; c < 3; c++) tick(32'h0000_0100, 1'b1, 1'b1);
        tick(32'h0, 1'b1, 1'b1);
        chk1 ("redirect_hit", o_av, 1'b1);
        chk32("redirect_inst", o_inst, memw(32'h0));
        for (int c = 4; c < 9; c++) tick(32'h0, 1'b1, 1'b1);
        tick(32'h0000_0100, 1'b1, 1'b1);
        chk1 ("return_hit", o_av, 1'b1);
        chk32("return_inst", o_inst, memw(32'h0000_0100));
        tick(32'h0000_0100, 1'b1, 1'b1);
        chk1("return_no_rd", o_rd, 1'b0);

        // Reset while the miss sits in WAIT.
        for (int c = 0; c < 5; c++) tick(32'h0000_0180, 1'b1, 1'b1);
        tick(32'h0000_0180, 1'b1, 1'b0);
        tick(32'h0000_0180, 1'b1, 1'b0);
        tick(32'h0000_0100, 1'b1, 1'b1);
        chk1("rstmid_0x100_miss", o_av, 1'b0);
        tick(32'h0000_0100, 1'b1, 1'b1);
        chk1 ("rstmid_rd", o_rd, 1'b1);
        chk32("rstmid_addr", o_maddr, 32'h0000_0100);
        run_until_hit(32'h0000_0100, 30);
        tick(32'h0000_0180, 1'b1, 1'b1);
        chk1("rstmid_partial_not_written", o_av, 1'b0);

        // Randomized traffic over a few conflicting tags and indices.
        begin
            logic [31:0] ra;
            ra = 32'h0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 9) < 3)
                    ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
                         | 32'($urandom_range(0, 3));
                tick(ra, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
